// File: rtl/uart_rx_data_sampler.sv
// UART RX oversampling front end: counts edges per bit, majority-votes 3 samples at mid-bit.
// Latency: strobe one cycle after edge_cnt==P/2; optional 2-flop RX_IN sync under UART_RX_SYNC_EN.
// Backpressure: none, one strobe per bit period while dat_samp_en is high.
module uart_rx_data_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  dat_samp_en,
    output logic                  sampled_data,
    output logic                  sampled,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);

    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(6);
    localparam logic [PRESCALE_W-1:0] ONE   = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO   = PRESCALE_W'(2);

    logic                  line;
    logic [PRESCALE_W-1:0] p_even;
    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] half;
    logic                  at_wrap;
    logic                  at_cap0;
    logic                  at_cap1;
    logic                  at_mid;
    logic                  s0;
    logic                  s1;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign line = sync_q[1];
`else
    assign line = RX_IN;
`endif

    // Odd ratios round down to even, anything below 6 is forced to 6.
    always_comb begin
        p_even  = {Prescale[PRESCALE_W-1:1], 1'b0};
        p_eff   = (p_even < P_MIN) ? P_MIN : p_even;
        half    = {1'b0, p_eff[PRESCALE_W-1:1]};
        at_wrap = (edge_cnt == p_eff - ONE);
        at_cap0 = (edge_cnt == half - TWO);
        at_cap1 = (edge_cnt == half - ONE);
        at_mid  = (edge_cnt == half);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            s0           <= 1'b0;
            s1           <= 1'b0;
            sampled      <= 1'b0;
            sampled_data <= 1'b1;
        end else if (!dat_samp_en) begin
            // Disable wins over a coincident mid-bit edge; sampled_data keeps its value.
            edge_cnt <= '0;
            bit_cnt  <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            sampled  <= 1'b0;
        end else begin
            edge_cnt <= at_wrap ? '0 : edge_cnt + ONE;
            if (at_wrap && (bit_cnt != '1)) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            if (at_cap0) begin
                s0 <= line;
            end
            if (at_cap1) begin
                s1 <= line;
            end
            sampled <= at_mid;
            if (at_mid) begin
                sampled_data <= (s0 & s1) | (s0 & line) | (s1 & line);
            end
        end
    end

endmodule

// File: doc/uart_rx_data_sampler.md
# uart_rx_data_sampler

Oversampling front end of the UART receiver. Counts prescale clock edges within each bit period and majority-votes three samples taken around the bit centre. Emits the bit value plus a one-cycle `sampled` strobe consumed directly by the receive deserializer, along with edge/bit counters used by the receive FSM.

## Interface
- `PRESCALE_W`, default 6: width of the `Prescale` input and of `edge_cnt`.
- `BIT_CNT_W`, default 4: width of `bit_cnt`.
- `CLK` input 1: sampling clock, equal to baud rate × Prescale.
- `Reset` input 1: asynchronous, active-low reset; one clock domain only.
- `RX_IN` input 1: serial line; idles high.
- `Prescale` input PRESCALE_W: oversampling ratio; legal values are even, 6..32.
- `dat_samp_en` input 1: sampling enable from the receive FSM.
- `sampled_data` output 1: majority-voted bit value.
- `sampled` output 1: one-cycle strobe marking that `sampled_data` is new.
- `edge_cnt` output PRESCALE_W: edge index within the current bit, 0..Prescale-1.
- `bit_cnt` output BIT_CNT_W: completed bit periods since enable.

## Operation
- Define `P = Prescale` and `M = P/2`. Compute M by dropping the LSB of `Prescale`; no divider is used.
- While `dat_samp_en` is 1:
  - `edge_cnt` increments every cycle.
  - When `edge_cnt == P-1`, `edge_cnt` wraps to 0 and `bit_cnt` increments.
  - `bit_cnt` saturates at all-ones and does not wrap.
- Sample capture:
  - At the clock edge where `edge_cnt == M-2`, the line value (post-sync) is captured into s0.
  - At `edge_cnt == M-1`, it is captured into s1.
- At the clock edge where `edge_cnt == M`:
  - `sampled_data` ← majority(s0, s1, current line).
  - `sampled` ← 1.
- At every other edge, `sampled` ← 0. Exactly one strobe is produced per bit period.
- While `dat_samp_en` is 0:
  - `edge_cnt`, `bit_cnt`, s0 and s1 are held at 0.
  - `sampled` is 0.
  - `sampled_data` holds its last value.
- `Prescale` must be stable while `dat_samp_en` is 1. Behaviour is undefined if it changes mid-frame.
- Illegal Prescale handling:
  - An odd value is treated as the next lower even value.
  - Values below 6 are treated as 6.
  - This clamping is combinational on the effective P.
- Reset values: `edge_cnt` = 0, `bit_cnt` = 0, s0 = s1 = 0, `sampled` = 0, `sampled_data` = 1 (idle level). Reset mid-frame aborts immediately. After `Reset` is released, counting starts from edge 0 on the first rising edge at which `dat_samp_en` is 1.

## Timing
- Enable to first edge: `dat_samp_en` rising at cycle t puts `edge_cnt` = 1 after the edge at t, i.e. the counter counts from 0 at t.
- Strobe position: `sampled` is high during the cycle after `edge_cnt == M`, so it is visible while `edge_cnt == M+1`. The deserializer samples it on the next edge.
- `bit_cnt` changes on the same edge that wraps `edge_cnt` to 0.
- Simultaneous events:
  - `dat_samp_en` falling on the edge where `edge_cnt == M`: the strobe is suppressed, because disable has priority.
  - `dat_samp_en` re-asserted in the cycle right after de-assertion: counting restarts from 0.
- Throughput: one bit per P cycles, with no dead cycles between bits.

## Configuration
- Macro `UART_RX_SYNC_EN`.
- Defined:
  - `RX_IN` passes through a 2-flop synchronizer (both flops reset to 1) before sampling.
  - Every capture point sees the line 2 cycles late, and the strobe timing relative to `edge_cnt` is unchanged.
  - The FSM start-bit detection is expected to account for this 2-cycle delay.
- Undefined: `RX_IN` is used directly, for when the line is already synchronous to `CLK`.

## Test plan
- **Reset values:** hold `Reset`=0 with `RX_IN` toggling → `sampled_data`=1, `sampled`=0, `edge_cnt`=0, `bit_cnt`=0. Release `Reset` with `dat_samp_en`=0 → all counters stay 0.
- **Clean byte at Prescale=8:** send 0xA5 LSB-first with start and stop bits, `dat_samp_en`=1 for 10 bits → 10 strobes, each 8 cycles apart, each in the cycle after `edge_cnt`==4. The values are 0,1,0,1,0,0,1,0,1,1, and `bit_cnt` ends at 10.
- **Glitch rejection at Prescale=16:** a bit is 1 with the line forced to 0 only on the cycle where `edge_cnt`==6 → `sampled_data`=1. Force 0 on both `edge_cnt`==6 and `edge_cnt`==7 → `sampled_data`=0.
- **Prescale=32 and clamping:** Prescale=32 → strobe after `edge_cnt`==16, with period 32. Prescale=7 → behaves as 6, with strobe after `edge_cnt`==3 and period 6.
- **Disable mid-bit:** `dat_samp_en` drops at `edge_cnt`==4 with Prescale=8 → no strobe, counters 0 on the next cycle, `sampled_data` retains its previous value. Re-enable → first strobe occurs 5 cycles after re-enable.
- **Saturation and async reset:** enable for 20 bits at Prescale=6 → `bit_cnt` saturates at 15. Assert `Reset` asynchronously mid-bit → outputs return to reset values before the next clock edge.
